// File: rtl/jtflane_pcm_arb.sv
// rtl/jtflane_pcm_arb.sv - round-robin arbiter sharing one SDRAM read port among four 007232 PCM ROM channels
// Optional watchdog on stalled SDRAM replies: define JTFLANE_PCMARB_WDOG_EN.
module jtflane_pcm_arb #(
  parameter int            AW   = 21,
  parameter logic [AW-1:0] OFFA = 21'h00000,
  parameter logic [AW-1:0] OFFB = 21'h20000,
  parameter logic [AW-1:0] OFFC = 21'h40000,
  parameter logic [AW-1:0] OFFD = 21'hC0000
)(
  input  logic          clk,
  input  logic          rstn,
  input  logic [16:0]   pcma_addr,
  input  logic [16:0]   pcmb_addr,
  input  logic [18:0]   pcmc_addr,
  input  logic [18:0]   pcmd_addr,
  input  logic          pcma_cs,
  input  logic          pcmb_cs,
  input  logic          pcmc_cs,
  input  logic          pcmd_cs,
  output logic [7:0]    pcma_dout,
  output logic [7:0]    pcmb_dout,
  output logic [7:0]    pcmc_dout,
  output logic [7:0]    pcmd_dout,
  output logic          pcma_ok,
  output logic          pcmb_ok,
  output logic          pcmc_ok,
  output logic          pcmd_ok,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
`ifdef JTFLANE_PCMARB_WDOG_EN
  output logic          wdog_err,
`endif
  input  logic          rom_ok
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [18:0]   w_addr [4];
  logic [AW-1:0] w_off  [4];
  logic [3:0]    w_cs, w_hit, w_pend;
  logic [18:0]   r_lat  [4];
  logic [7:0]    r_d    [4];
  logic [3:0]    r_v;
  logic [1:0]    r_last, r_gnt, w_sel, w_idx;
  logic          w_grant, w_done, r_mask, r_rom_cs;
  logic [AW-1:0] r_rom_addr;
  logic [7:0]    w_data;
`ifdef JTFLANE_PCMARB_WDOG_EN
  logic [7:0]    r_wdog;
  logic          r_wdog_err, w_to;
`endif

  assign w_addr[0] = {2'b00, pcma_addr};
  assign w_addr[1] = {2'b00, pcmb_addr};
  assign w_addr[2] = pcmc_addr;
  assign w_addr[3] = pcmd_addr;
  assign w_off[0]  = OFFA;
  assign w_off[1]  = OFFB;
  assign w_off[2]  = OFFC;
  assign w_off[3]  = OFFD;
  assign w_cs      = {pcmd_cs, pcmc_cs, pcmb_cs, pcma_cs};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_hit[i]  = w_cs[i] && r_v[i] && (w_addr[i] == r_lat[i]);
      w_pend[i] = w_cs[i] && !w_hit[i];
    end
  end

  // Scan downwards so the channel right after r_last is assigned last and wins.
  always_comb begin
    w_sel = r_last;
    w_idx = r_last;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_last + 2'(k);
      if (w_pend[w_idx]) w_sel = w_idx;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
`ifdef JTFLANE_PCMARB_WDOG_EN
    w_to        = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|w_pend) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!r_mask && rom_ok) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`ifdef JTFLANE_PCMARB_WDOG_EN
        else if (r_wdog == 8'hFF) begin
          w_done      = 1'b1;
          w_to        = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef JTFLANE_PCMARB_WDOG_EN
  assign w_data = w_to ? 8'h00 : rom_data;
`else
  assign w_data = rom_data;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_rom_cs   <= 1'b0;
      r_rom_addr <= '0;
      r_mask     <= 1'b0;
      r_v        <= '0;
      r_last     <= 2'd3;
      r_gnt      <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_lat[i] <= '0;
        r_d[i]   <= '0;
      end
    end else begin
      r_state  <= w_state_nxt;
      r_rom_cs <= (w_state_nxt == ST_WAIT);
      // The first WAIT cycle may still carry rom_ok from the previous slot.
      r_mask   <= w_grant;
      if (w_grant) begin
        r_gnt        <= w_sel;
        r_lat[w_sel] <= w_addr[w_sel];
        r_v[w_sel]   <= 1'b0;
        r_rom_addr   <= w_off[w_sel] + AW'(w_addr[w_sel]);
      end
      if (w_done) begin
        r_d[r_gnt] <= w_data;
        r_v[r_gnt] <= 1'b1;
        r_last     <= r_gnt;
      end
    end
  end

`ifdef JTFLANE_PCMARB_WDOG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wdog     <= 8'd0;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog <= (r_state == ST_WAIT) ? r_wdog + 8'd1 : 8'd0;
      if (w_to) r_wdog_err <= 1'b1;
    end
  end
  assign wdog_err = r_wdog_err;
`endif

  assign rom_cs    = r_rom_cs;
  assign rom_addr  = r_rom_addr;
  assign pcma_dout = r_d[0];
  assign pcmb_dout = r_d[1];
  assign pcmc_dout = r_d[2];
  assign pcmd_dout = r_d[3];
  assign pcma_ok   = w_hit[0];
  assign pcmb_ok   = w_hit[1];
  assign pcmc_ok   = w_hit[2];
  assign pcmd_ok   = w_hit[3];

endmodule

// File: tb/tb_jtflane_pcm_arb.sv
// tb/tb_jtflane_pcm_arb.sv - self-checking bench for jtflane_pcm_arb
`timescale 1ns/1ps
module tb_jtflane_pcm_arb;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [18:0] t_addr [4];
  logic [3:0]  t_cs = 4'b0;
  logic [7:0]  d_a, d_b, d_c, d_d;
  logic        ok_a, ok_b, ok_c, ok_d;
  logic [20:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data = 8'h00;
  logic        rom_ok = 1'b0;
`ifdef JTFLANE_PCMARB_WDOG_EN
  logic        wdog_err;
`endif
  logic [7:0]  t_dout [4];
  logic [3:0]  okv;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [20:0] exp_q [$];
  int          mem_lat = 2;
  int          mcnt = 0;
  bit          hold_ok = 1'b0;
  bit          prev_cs = 1'b0;

  typedef struct {
    int          ch;
    logic [18:0] addr;
    logic [20:0] exp_addr;
  } vec_t;
  vec_t vecs [8];

  jtflane_pcm_arb dut (
    .clk       (clk),
    .rstn      (rstn),
    .pcma_addr (t_addr[0][16:0]),
    .pcmb_addr (t_addr[1][16:0]),
    .pcmc_addr (t_addr[2]),
    .pcmd_addr (t_addr[3]),
    .pcma_cs   (t_cs[0]),
    .pcmb_cs   (t_cs[1]),
    .pcmc_cs   (t_cs[2]),
    .pcmd_cs   (t_cs[3]),
    .pcma_dout (d_a),
    .pcmb_dout (d_b),
    .pcmc_dout (d_c),
    .pcmd_dout (d_d),
    .pcma_ok   (ok_a),
    .pcmb_ok   (ok_b),
    .pcmc_ok   (ok_c),
    .pcmd_ok   (ok_d),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_data  (rom_data),
`ifdef JTFLANE_PCMARB_WDOG_EN
    .wdog_err  (wdog_err),
`endif
    .rom_ok    (rom_ok)
  );

  assign t_dout[0] = d_a;
  assign t_dout[1] = d_b;
  assign t_dout[2] = d_c;
  assign t_dout[3] = d_d;
  assign okv = {ok_d, ok_c, ok_b, ok_a};

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [20:0] a);
    return a[7:0] ^ 8'h6E;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM model: ok after mem_lat cycles of rom_cs (0 = never), data is a function of the address.
  always @(posedge clk) begin
    #1;
    if (!rom_cs) mcnt = 0;
    else mcnt++;
    rom_ok   = hold_ok || (rom_cs && mem_lat != 0 && mcnt >= mem_lat);
    rom_data = memf(rom_addr);
  end

  // Scoreboard: each new downstream request must match the next expected address.
  always @(posedge clk) begin
    #1;
    if (rom_cs && !prev_cs) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rom_cs: got addr %0h expected no request", rom_addr);
      end else begin
        check("rom_addr", 32'(rom_addr), 32'(exp_q.pop_front()));
      end
    end
    prev_cs = rom_cs;
  end

  task automatic wait_ok(input int ch, input int budget, output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (cyc < budget && !got) begin
      @(posedge clk);
      #2;
      cyc++;
      got = okv[ch];
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout_ok: got no ok on ch %0d expected ok within %0d cycles", ch, budget);
    end
  endtask

  task automatic request(input int ch, input logic [18:0] a, input logic [20:0] ea);
    @(negedge clk);
    t_addr[ch] = a;
    t_cs[ch]   = 1'b1;
    exp_q.push_back(ea);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    bit got;
    bit early;
    vecs[0] = '{0, 19'h00000, 21'h000000};
    vecs[1] = '{0, 19'h1FFFF, 21'h01FFFF};
    vecs[2] = '{1, 19'h00000, 21'h020000};
    vecs[3] = '{1, 19'h1FFFF, 21'h03FFFF};
    vecs[4] = '{2, 19'h00000, 21'h040000};
    vecs[5] = '{2, 19'h7FFFF, 21'h0BFFFF};
    vecs[6] = '{3, 19'h00000, 21'h0C0000};
    vecs[7] = '{3, 19'h7FFFF, 21'h13FFFF};
    for (int i = 0; i < 4; i++) t_addr[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_rom_cs", 32'(rom_cs), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_ok", 32'(okv), 32'd0);
    check("rst_dout_a", 32'(d_a), 32'd0);
`ifdef JTFLANE_PCMARB_WDOG_EN
    check("rst_wdog_err", 32'(wdog_err), 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // Single fetch on B, then stable-address hits
    request(1, 19'h01234, 21'h021234);
    wait_ok(1, 20, cyc, got);
    check("b_dout", 32'(d_b), 32'h5A);
    idle(5);
    check("b_hold_ok", 32'(ok_b), 32'd1);
    @(negedge clk);
    t_cs[1] = 1'b0;
    #1;
    check("b_drop_ok", 32'(ok_b), 32'd0);
    idle(2);
    @(negedge clk);
    t_cs[1] = 1'b1;
    #1;
    check("b_hit_ok", 32'(ok_b), 32'd1);
    idle(3);
    @(negedge clk);
    t_cs[1] = 1'b0;

    // Table of single requests across channel address ranges
    for (int i = 0; i < 8; i++) begin
      request(vecs[i].ch, vecs[i].addr, vecs[i].exp_addr);
      wait_ok(vecs[i].ch, 20, cyc, got);
      check($sformatf("vec%0d_dout", i), 32'(t_dout[vecs[i].ch]), 32'(memf(vecs[i].exp_addr)));
      @(negedge clk);
      t_cs[vecs[i].ch] = 1'b0;
      #1;
      check($sformatf("vec%0d_drop_ok", i), 32'(okv[vecs[i].ch]), 32'd0);
      idle(1);
    end

    // All four requesting at once: round robin A,B,C,D
    @(negedge clk);
    t_addr[0] = 19'h000AB; t_addr[1] = 19'h000CD; t_addr[2] = 19'h123EF; t_addr[3] = 19'h45601;
    exp_q.push_back(21'h0000AB);
    exp_q.push_back(21'h0200CD);
    exp_q.push_back(21'h0523EF);
    exp_q.push_back(21'h105601);
    t_cs = 4'hF;
    cyc = 0;
    while (cyc < 80 && okv != 4'hF) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("all4_ok", 32'(okv), 32'hF);
    check("all4_dout_a", 32'(d_a), 32'(memf(21'h0000AB)));
    check("all4_dout_b", 32'(d_b), 32'(memf(21'h0200CD)));
    check("all4_dout_c", 32'(d_c), 32'(memf(21'h0523EF)));
    check("all4_dout_d", 32'(d_d), 32'(memf(21'h105601)));
    check("all4_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    t_cs = 4'h0;
    idle(2);

    // A and C re-raised together: A then C
    @(negedge clk);
    t_addr[0] = 19'h000AC; t_addr[2] = 19'h12340;
    exp_q.push_back(21'h0000AC);
    exp_q.push_back(21'h052340);
    t_cs = 4'b0101;
    cyc = 0;
    while (cyc < 40 && okv != 4'b0101) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("ac_ok", 32'(okv), 32'h5);
    check("ac_dout_c", 32'(d_c), 32'(memf(21'h052340)));
    @(negedge clk);
    t_cs = 4'h0;
    idle(2);

    // rom_ok held high: first WAIT cycle masked, capture on the second
    hold_ok = 1'b1;
    idle(2);
    request(0, 19'h00077, 21'h000077);
    wait_ok(0, 20, cyc, got);
    check("hold_latency", 32'(cyc), 32'd3);
    check("hold_dout", 32'(d_a), 32'(memf(21'h000077)));
    @(negedge clk);
    t_cs = 4'h0;
    hold_ok = 1'b0;
    idle(2);

    // D address changes mid-flight: refetch before ok
    mem_lat = 4;
    request(3, 19'h00010, 21'h0C0010);
    exp_q.push_back(21'h0C0011);
    repeat (2) @(posedge clk);
    @(negedge clk);
    t_addr[3] = 19'h00011;
    cyc = 0;
    early = 1'b0;
    while (cyc < 40 && !ok_d) begin
      @(posedge clk);
      #2;
      cyc++;
      if (ok_d && exp_q.size() != 0) early = 1'b1;
    end
    check("d_change_ok", 32'(ok_d), 32'd1);
    check("d_change_no_early_ok", 32'(early), 32'd0);
    check("d_change_dout", 32'(d_d), 32'h7F);
    @(negedge clk);
    t_cs = 4'h0;
    idle(2);

    // Reset pulsed during WAIT, late rom_ok ignored
    request(0, 19'h00100, 21'h000100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rstwait_rom_cs", 32'(rom_cs), 32'd0);
    check("rstwait_ok", 32'(okv), 32'd0);
    t_cs = 4'h0;
    idle(2);
    hold_ok = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check($sformatf("late_ok_rom_cs%0d", i), 32'(rom_cs), 32'd0);
      check($sformatf("late_ok_okv%0d", i), 32'(okv), 32'd0);
    end
    hold_ok = 1'b0;
    idle(2);
    @(negedge clk);
    t_cs[0] = 1'b1;
    #1;
    check("rst_cleared_valid", 32'(ok_a), 32'd0);
    exp_q.push_back(21'h000100);
    wait_ok(0, 20, cyc, got);
    check("rst_refetch_dout", 32'(d_a), 32'h6E);
    @(negedge clk);
    t_cs = 4'h0;
    idle(2);

`ifdef JTFLANE_PCMARB_WDOG_EN
    // Watchdog: no rom_ok ever
    mem_lat = 0;
    request(1, 19'h00055, 21'h020055);
    wait_ok(1, 300, cyc, got);
    check("wdog_dout", 32'(d_b), 32'h00);
    check("wdog_ok", 32'(ok_b), 32'd1);
    check("wdog_err", 32'(wdog_err), 32'd1);
    @(negedge clk);
    t_cs = 4'h0;
    mem_lat = 2;
    idle(2);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
